// File: rtl/alu_mul_sequencer.sv
// Shift-add unsigned multiplier sequencer that borrows the shared 32-bit ALU.
// Each RUN cycle conditionally accumulates mcand into prod, then shifts mcand left and mplr right.
module alu_mul_sequencer #(
    parameter int WIDTH    = 32,
    parameter int ITER_MAX = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_mcand,
    input  logic [WIDTH-1:0] i_mplr,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_ovf,
    output logic [3:0]       o_alu_ctl,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    input  logic [WIDTH-1:0] i_alu_out,
    input  logic             i_alu_zero,
    input  logic             i_alu_ovf
);
    localparam int         CW      = $clog2(ITER_MAX + 1);
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0000;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] prod, mcand, mplr;
    logic [WIDTH-1:0] prod_nxt, mplr_shr;
    logic [CW-1:0]    count;
    logic             lost;

    // Zero flag is reserved; keep it visibly consumed.
    logic alu_zero_unused;
    assign alu_zero_unused = i_alu_zero;

    assign mplr_shr = mplr >> 1;
    assign prod_nxt = mplr[0] ? i_alu_out : prod;
    assign o_busy   = (state != IDLE);
    assign o_done   = (state == DONE);

    always_comb begin
        state_nxt = state;
        o_alu_ctl = ALU_AND;
        o_alu_a   = '0;
        o_alu_b   = '0;
        case (state)
            IDLE: if (i_start) state_nxt = RUN;
            RUN: begin
                o_alu_ctl = ALU_ADD;
                o_alu_a   = prod;
                o_alu_b   = mcand;
                if (mplr_shr == '0 || count == CW'(ITER_MAX - 1)) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            prod     <= '0;
            mcand    <= '0;
            mplr     <= '0;
            count    <= '0;
            lost     <= 1'b0;
            o_ovf    <= 1'b0;
            o_result <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (i_start) begin
                    mcand <= i_mcand;
                    mplr  <= i_mplr;
                    prod  <= '0;
                    count <= '0;
                    lost  <= 1'b0;
                    o_ovf <= 1'b0;
                end
                RUN: begin
                    prod <= prod_nxt;
                    // An add after a bit fell off mcand means the true product is already too wide.
                    if (mplr[0] && (i_alu_ovf || lost)) o_ovf <= 1'b1;
                    if (mcand[WIDTH-1]) lost <= 1'b1;
                    mcand <= mcand << 1;
                    mplr  <= mplr_shr;
                    count <= count + 1'b1;
                    // Result is registered as DONE is entered so it is valid with the pulse.
                    if (state_nxt == DONE) o_result <= prod_nxt;
                end
                default: ;
            endcase
        end
    end
endmodule
